mmio_host_requester: RTL and testbench

- Host-side initiator for the CCI-P MMIO path: turns a simple command/response interface into single-cycle MMIO read/write request pulses (address, TID, data) toward an AFU.
- Collects the AFU's read responses (valid/TID/data) and matches them to the outstanding request.
- Used as the synthesizable stimulus/bring-up front end for MMIO-mapped AFU registers (DFH, AFU ID, user registers) and in loopback benches.
- One request outstanding at a time; includes read timeout and misalignment checking.

---
 rtl/mmio_host_pkg.sv | 23 ++
 rtl/mmio_rsp_timer.sv | 40 ++++
 rtl/mmio_host_requester.sv | 187 ++++++++++++++++++
 tb/tb_mmio_host_requester.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_host_pkg.sv
// Shared types and constants for the host-side MMIO requester.
package mmio_host_pkg;

  // Requester FSM states
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRsp,
    StResp
  } t_mmio_host_state;

  // Device feature header layout (32-bit word addresses)
  localparam logic [15:0] AddrAfuDfh  = 16'h0000;
  localparam logic [15:0] AddrAfuIdL  = 16'h0002;
  localparam logic [15:0] AddrAfuIdH  = 16'h0004;
  localparam logic [15:0] AddrRsvd0   = 16'h0006;
  localparam logic [15:0] AddrRsvd1   = 16'h0008;
  localparam logic [15:0] AddrUserReg = 16'h0020;

  // Cycles spent waiting for a read response before giving up
  localparam int unsigned DefaultTimeout = 256;

endpackage

// File: rtl/mmio_rsp_timer.sv
// Read-response wait counter: synchronous clear, count enable, terminal-count flag.
module mmio_rsp_timer
  import mmio_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] TcVal = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/mmio_host_requester.sv
// Host-side MMIO initiator: command/response front end producing single-cycle
// MMIO read/write pulses, with read-response matching, timeout and alignment checks.
module mmio_host_requester
  import mmio_host_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TID_W   = 9,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              rsp_misalign,
  output logic              mmio_wr_valid,
  output logic              mmio_rd_valid,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [TID_W-1:0]  mmio_tid,
  output logic [DATA_W-1:0] mmio_wdata,
  input  logic              afu_rd_valid,
  input  logic [TID_W-1:0]  afu_rd_tid,
  input  logic [DATA_W-1:0] afu_rd_data
);

  t_mmio_host_state state_q, state_d;

  logic [TID_W-1:0]  tid_q, tid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              rsp_misalign_q, rsp_misalign_d;
  logic              mmio_wr_valid_q, mmio_wr_valid_d;
  logic              mmio_rd_valid_q, mmio_rd_valid_d;
  logic [ADDR_W-1:0] mmio_addr_q, mmio_addr_d;
  logic [TID_W-1:0]  mmio_tid_q, mmio_tid_d;
  logic [DATA_W-1:0] mmio_wdata_q, mmio_wdata_d;

  logic cmd_hs, cmd_misalign, rsp_match;
  logic tmr_clr, tmr_en, tmr_tc;

  assign cmd_hs       = cmd_valid & cmd_ready_q;
  // 64-bit accesses must sit on an even 32-bit word
  assign cmd_misalign = cmd_addr[0];
  // mmio_tid_q holds the TID of the outstanding read
  assign rsp_match    = afu_rd_valid & (afu_rd_tid == mmio_tid_q);

  mmio_rsp_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_rsp_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and TID counter; a response match beats the timeout
  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          state_d = cmd_misalign ? StResp : StIssue;
        end
      end
      StIssue: begin
        state_d = mmio_wr_valid_q ? StResp : StWaitRsp;
        tid_d   = tid_q + 1'b1;
      end
      StWaitRsp: begin
        if (rsp_match || tmr_tc) begin
          state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and timer control
  always_comb begin
    cmd_ready_d     = 1'b0;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = '0;
    rsp_timeout_d   = 1'b0;
    rsp_misalign_d  = 1'b0;
    mmio_wr_valid_d = 1'b0;
    mmio_rd_valid_d = 1'b0;
    mmio_addr_d     = mmio_addr_q;
    mmio_tid_d      = mmio_tid_q;
    mmio_wdata_d    = mmio_wdata_q;
    tmr_clr         = 1'b0;
    tmr_en          = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready_d = ~cmd_hs;
        if (cmd_hs && cmd_misalign) begin
          rsp_valid_d    = 1'b1;
          rsp_misalign_d = 1'b1;
        end else if (cmd_hs) begin
          mmio_wr_valid_d = cmd_write;
          mmio_rd_valid_d = ~cmd_write;
          mmio_addr_d     = cmd_addr;
          mmio_tid_d      = tid_q;
          mmio_wdata_d    = cmd_write ? cmd_wdata : '0;
        end
      end
      StIssue: begin
        // Writes are posted and complete right after the pulse
        rsp_valid_d = mmio_wr_valid_q;
        tmr_clr     = 1'b1;
      end
      StWaitRsp: begin
        if (rsp_match) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = afu_rd_data;
        end else if (tmr_tc) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StResp: cmd_ready_d = 1'b1;
      default: cmd_ready_d = 1'b0;
    endcase
  end

  // Output and TID registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tid_q           <= '0;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_timeout_q   <= 1'b0;
      rsp_misalign_q  <= 1'b0;
      mmio_wr_valid_q <= 1'b0;
      mmio_rd_valid_q <= 1'b0;
      mmio_addr_q     <= '0;
      mmio_tid_q      <= '0;
      mmio_wdata_q    <= '0;
    end else begin
      tid_q           <= tid_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_timeout_q   <= rsp_timeout_d;
      rsp_misalign_q  <= rsp_misalign_d;
      mmio_wr_valid_q <= mmio_wr_valid_d;
      mmio_rd_valid_q <= mmio_rd_valid_d;
      mmio_addr_q     <= mmio_addr_d;
      mmio_tid_q      <= mmio_tid_d;
      mmio_wdata_q    <= mmio_wdata_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_misalign  = rsp_misalign_q;
  assign mmio_wr_valid = mmio_wr_valid_q;
  assign mmio_rd_valid = mmio_rd_valid_q;
  assign mmio_addr     = mmio_addr_q;
  assign mmio_tid      = mmio_tid_q;
  assign mmio_wdata    = mmio_wdata_q;

endmodule

// File: tb/tb_mmio_host_requester.sv
// Bench for mmio_host_requester: AFU register model plus response scoreboard.
module tb_mmio_host_requester;
  import mmio_host_pkg::*;

  localparam int unsigned TimeoutTb = 16;
  localparam logic [63:0] UserData  = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] DfhData   = 64'h1000_0100_0000_0000;
  localparam logic [63:0] IdLData   = 64'hA5A5_5A5A_0123_4567;
  localparam logic [63:0] RdJunk    = 64'hFFFF_0000_FFFF_0000;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid, rsp_timeout, rsp_misalign;
  logic [63:0] rsp_rdata;
  logic        mmio_wr_valid, mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        afu_rd_valid;
  logic [8:0]  afu_rd_tid;
  logic [63:0] afu_rd_data;

  mmio_host_requester #(
    .ADDR_W  (16),
    .DATA_W  (64),
    .TID_W   (9),
    .TIMEOUT (TimeoutTb)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_timeout   (rsp_timeout),
    .rsp_misalign  (rsp_misalign),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_addr     (mmio_addr),
    .mmio_tid      (mmio_tid),
    .mmio_wdata    (mmio_wdata),
    .afu_rd_valid  (afu_rd_valid),
    .afu_rd_tid    (afu_rd_tid),
    .afu_rd_data   (afu_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] rdata;
    logic        to;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [8:0]  exp_tid = '0;

  // AFU model configuration (written by the main thread only)
  int          afu_lat       = 1;
  bit          afu_silent    = 1'b0;
  bit          afu_wrong_tid = 1'b0;
  int          inject_cyc    = -1;
  logic [8:0]  inject_tid    = '0;

  // AFU model state (written by the AFU process only)
  int          cyc      = 0;
  bit          pend     = 1'b0;
  int          pend_cnt = 0;
  logic [8:0]  pend_tid;
  logic [63:0] pend_data;
  logic [63:0] mem [logic [15:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // AFU: register file answering reads after afu_lat cycles, optional wrong-TID decoy
  initial begin
    afu_rd_valid = 1'b0;
    afu_rd_tid   = '0;
    afu_rd_data  = '0;
    mem[AddrAfuDfh] = DfhData;
    mem[AddrAfuIdL] = IdLData;
    forever begin
      @(negedge clk);
      cyc++;
      afu_rd_valid = 1'b0;
      afu_rd_tid   = '0;
      afu_rd_data  = '0;
      if (pend) begin
        if (pend_cnt == 1) begin
          afu_rd_valid = 1'b1;
          afu_rd_tid   = pend_tid;
          afu_rd_data  = pend_data;
          pend         = 1'b0;
        end else begin
          if (afu_wrong_tid && pend_cnt == 2) begin
            afu_rd_valid = 1'b1;
            afu_rd_tid   = pend_tid ^ 9'h1;
            afu_rd_data  = 64'h0BAD_0BAD_0BAD_0BAD;
          end
          pend_cnt--;
        end
      end
      if (cyc == inject_cyc) begin
        afu_rd_valid = 1'b1;
        afu_rd_tid   = inject_tid;
        afu_rd_data  = 64'h5A5A_5A5A_5A5A_5A5A;
      end
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (mmio_rd_valid && !afu_silent) begin
          pend      = 1'b1;
          pend_cnt  = afu_lat;
          pend_tid  = mmio_tid;
          pend_data = mem.exists(mmio_addr) ? mem[mmio_addr] : 64'h0;
        end
        if (mmio_wr_valid) mem[mmio_addr] = mmio_wdata;
      end
    end
  end

  // Issue one command, watch the MMIO side, then score the response it produces
  task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input logic to, input int lat);
    exp_t        e;
    logic [8:0]  etid;
    int          got_lat, npulse, p_k;
    logic        p_wr, p_rd, g_to, g_mis;
    logic [8:0]  p_tid;
    logic [15:0] p_addr;
    logic [63:0] p_wdata, g_rdata;
    e.rdata = rdata;
    e.to    = to;
    e.mis   = addr[0];
    e.lat   = lat;
    sb.push_back(e);
    etid = exp_tid;
    if (!addr[0]) exp_tid = exp_tid + 9'd1;
    check("idle_ready", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    got_lat = -1;
    npulse  = 0;
    p_k = 0; p_wr = 1'b0; p_rd = 1'b0; p_tid = '0; p_addr = '0; p_wdata = '0;
    g_rdata = '0; g_to = 1'b0; g_mis = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0;
        check("busy_ready", {63'd0, cmd_ready}, 64'd0);
      end
      if (mmio_wr_valid || mmio_rd_valid) begin
        npulse++;
        p_k = k; p_wr = mmio_wr_valid; p_rd = mmio_rd_valid;
        p_tid = mmio_tid; p_addr = mmio_addr; p_wdata = mmio_wdata;
      end
      if (rsp_valid) begin
        got_lat = k;
        g_rdata = rsp_rdata; g_to = rsp_timeout; g_mis = rsp_misalign;
        break;
      end
    end
    e = sb.pop_front();
    check("rsp_latency", 64'(got_lat), 64'(e.lat));
    check("rsp_rdata", g_rdata, e.rdata);
    check("rsp_timeout", {63'd0, g_to}, {63'd0, e.to});
    check("rsp_misalign", {63'd0, g_mis}, {63'd0, e.mis});
    check("pulse_count", 64'(npulse), e.mis ? 64'd0 : 64'd1);
    if (!e.mis && npulse == 1) begin
      check("pulse_cycle", 64'(p_k), 64'd1);
      check("pulse_wr", {63'd0, p_wr}, {63'd0, wr});
      check("pulse_rd", {63'd0, p_rd}, {63'd0, ~wr});
      check("pulse_tid", {55'd0, p_tid}, {55'd0, etid});
      check("pulse_addr", {48'd0, p_addr}, {48'd0, addr});
      check("pulse_wdata", p_wdata, wr ? wdata : 64'd0);
    end
    @(negedge clk);
    check("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("post_rsp_rdata", rsp_rdata, 64'd0);
    check("post_ready", {63'd0, cmd_ready}, 64'd1);
  endtask

  task automatic watch_no_rsp(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_pulses", {62'd0, mmio_wr_valid, mmio_rd_valid}, 64'd0);
    check("rst_tid", {55'd0, mmio_tid}, 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back a user register, 1-cycle AFU
    afu_lat = 1;
    do_cmd(1'b1, AddrUserReg, UserData, 64'd0, 1'b0, 2);
    do_cmd(1'b0, AddrUserReg, RdJunk, UserData, 1'b0, 3);

    // DFH read with a slow AFU
    afu_lat = 5;
    do_cmd(1'b0, AddrAfuDfh, RdJunk, DfhData, 1'b0, 7);

    // Silent AFU: timeout, then a stale response that must be dropped
    afu_silent = 1'b1;
    do_cmd(1'b0, AddrAfuIdH, RdJunk, 64'd0, 1'b1, 2 + TimeoutTb);
    inject_tid = exp_tid - 9'd1;
    inject_cyc = cyc + 2;
    watch_no_rsp("stale_after_timeout", 8);
    afu_silent = 1'b0;
    afu_lat    = 1;
    do_cmd(1'b0, AddrUserReg, RdJunk, UserData, 1'b0, 3);

    // Misaligned read, then confirm the TID did not advance
    do_cmd(1'b0, 16'h0021, RdJunk, 64'd0, 1'b0, 1);
    do_cmd(1'b0, AddrUserReg, RdJunk, UserData, 1'b0, 3);

    // Wrong-TID decoy during WAIT_RSP
    afu_lat       = 4;
    afu_wrong_tid = 1'b1;
    do_cmd(1'b0, AddrUserReg, RdJunk, UserData, 1'b0, 6);
    afu_wrong_tid = 1'b0;

    // Response lands on the terminal-count cycle: match wins
    afu_lat = TimeoutTb;
    do_cmd(1'b0, AddrAfuIdL, RdJunk, IdLData, 1'b0, 2 + TimeoutTb);

    // TID wrap
    afu_lat = 1;
    for (int i = 0; i < 520; i++) begin
      do_cmd(1'b0, AddrUserReg, RdJunk, UserData, 1'b0, 3);
    end

    // Asynchronous reset while waiting for a read response
    afu_silent = 1'b1;
    check("pre_rst_ready", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = AddrUserReg;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_pulse", {63'd0, mmio_rd_valid}, 64'd1);
    inject_tid = mmio_tid;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", {63'd0, cmd_ready}, 64'd1);
    check("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("arst_tid", {55'd0, mmio_tid}, 64'd0);
    check("arst_addr", {48'd0, mmio_addr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_tid = '0;
    inject_cyc = cyc + 1;
    watch_no_rsp("stale_after_reset", 5);
    afu_silent = 1'b0;
    do_cmd(1'b0, AddrUserReg, RdJunk, UserData, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
